// File: rtl/tile_fetch.sv
// tile_fetch: tile-map pixel generator feeding vga_ctrl pix_data.
// A requested screen coordinate is mapped onto a MAP_W x MAP_H grid of
// 16x16 tiles. The block reads the tile index from the map RAM, fetches a
// 4-bit pixel from an external pattern ROM, and resolves it through a
// 16-entry RGB565 palette. The coordinate-to-pixel latency is fixed at
// 5 cycles.
// A valid/ready port writes the map and the palette. A sweep FSM clears the map.
// Optional feature macro: TILE_SCROLL_EN builds per-frame scroll latches and
// the wrap arithmetic. Without it, xs = pix_x and ys = pix_y.
module tile_fetch #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    output logic [15:0] pix_data,
    output logic [15:0] pat_addr,
    input  logic [3:0]  pat_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic        wr_sel,
    input  logic [10:0] wr_addr,
    input  logic [15:0] wr_data,
    input  logic [9:0]  scroll_x,
    input  logic [8:0]  scroll_y,
    input  logic        clr_req,
    output logic        clr_busy,
    output logic        clr_done
);

    localparam int MAP_W = H_RES / 16;
    localparam int MAP_H = V_RES / 16;
    localparam int MAP_N = MAP_W * MAP_H;

    localparam logic [10:0] H_RES_L    = 11'(H_RES);
    localparam logic [10:0] V_RES_L    = 11'(V_RES);
    localparam logic [10:0] MAP_W_L    = 11'(MAP_W);
    localparam logic [10:0] MAP_N_L    = 11'(MAP_N);
    localparam logic [10:0] MAP_LAST_L = 11'(MAP_N - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clr_state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic        s0_valid_s;
    logic [9:0]  xs_s;
    logic [9:0]  ys_s;

    logic        s0_valid_r;
    logic [9:0]  xs_r;
    logic [9:0]  ys_r;

    logic [10:0] map_rd_addr_s;
    logic [7:0]  map_q_r;
    logic        s1_valid_r;
    logic [3:0]  s1_xl_r;
    logic [3:0]  s1_yl_r;

    logic        s2_valid_r;
    logic [15:0] pat_addr_r;
    logic        s3_valid_r;
    logic [15:0] pix_data_r;

    logic [7:0]  map_mem [0:MAP_N-1];
    logic [15:0] pal_r   [0:15];

    logic        map_we_s;
    logic [10:0] map_wa_s;
    logic [7:0]  map_wd_s;
    logic        wr_fire_s;

    clr_state_t  state_r;
    clr_state_t  state_s;
    logic [10:0] clr_cnt_r;
    logic [10:0] clr_cnt_s;
    logic        wr_ready_r;
    logic        clr_busy_r;
    logic        clr_done_r;

    // ------------------------------------------------------------------
    // S0: active test and scrolled coordinate
    // ------------------------------------------------------------------
    assign s0_valid_s = ({1'b0, pix_x} < H_RES_L) && ({1'b0, pix_y} < V_RES_L);

`ifdef TILE_SCROLL_EN
    logic [9:0]  scroll_lx_r;
    logic [8:0]  scroll_ly_r;
    logic [10:0] xsum_s;
    logic [10:0] ysum_s;

    assign xsum_s = {1'b0, pix_x} + {1'b0, scroll_lx_r};
    assign ysum_s = {1'b0, pix_y} + {2'b00, scroll_ly_r};

    // Wrap the scrolled coordinate back into the active area (one subtract suffices).
    always_comb begin
        xs_s = xsum_s[9:0];
        ys_s = ysum_s[9:0];
        if (xsum_s >= H_RES_L) begin
            xs_s = 10'(xsum_s - H_RES_L);
        end else begin
            xs_s = xsum_s[9:0];
        end
        if (ysum_s >= V_RES_L) begin
            ys_s = 10'(ysum_s - V_RES_L);
        end else begin
            ys_s = ysum_s[9:0];
        end
    end

    // Scroll offsets load once per frame at (0,0); an out-of-range axis keeps its old value.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            scroll_lx_r <= 10'd0;
            scroll_ly_r <= 9'd0;
        end else if ((pix_x == 10'd0) && (pix_y == 10'd0)) begin
            if ({1'b0, scroll_x} < H_RES_L) begin
                scroll_lx_r <= scroll_x;
            end
            if ({2'b00, scroll_y} < V_RES_L) begin
                scroll_ly_r <= scroll_y;
            end
        end
    end
`else
    logic unused_scroll_s;

    assign xs_s            = pix_x;
    assign ys_s            = pix_y;
    assign unused_scroll_s = ^{scroll_x, scroll_y};
`endif

    // S0 pipeline register: active flag and effective coordinate.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s0_valid_r <= 1'b0;
            xs_r       <= 10'd0;
            ys_r       <= 10'd0;
        end else begin
            s0_valid_r <= s0_valid_s;
            xs_r       <= xs_s;
            ys_r       <= ys_s;
        end
    end

    // ------------------------------------------------------------------
    // S1: map address (constant multiply by MAP_W) and map RAM read
    // ------------------------------------------------------------------
    // Inactive pixels read entry 0 so the RAM index never leaves the map.
    always_comb begin
        map_rd_addr_s = 11'd0;
        if (s0_valid_r) begin
            map_rd_addr_s = (11'(ys_r[9:4]) * MAP_W_L) + 11'(xs_r[9:4]);
        end else begin
            map_rd_addr_s = 11'd0;
        end
    end

    // Map RAM: one write port and one registered display read port; a collision returns old data.
    always_ff @(posedge vga_clk) begin
        if (map_we_s) begin
            map_mem[map_wa_s] <= map_wd_s;
        end
        map_q_r <= map_mem[map_rd_addr_s];
    end

    // S1 side-band: carry the active flag and the in-tile offsets alongside the RAM read.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1_valid_r <= 1'b0;
            s1_xl_r    <= 4'd0;
            s1_yl_r    <= 4'd0;
        end else begin
            s1_valid_r <= s0_valid_r;
            s1_xl_r    <= xs_r[3:0];
            s1_yl_r    <= ys_r[3:0];
        end
    end

    // ------------------------------------------------------------------
    // S2..S4: pattern ROM address, ROM return, palette lookup
    // ------------------------------------------------------------------
    // Registers the pattern address, then tracks validity while the ROM responds.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s2_valid_r <= 1'b0;
            pat_addr_r <= 16'h0000;
            s3_valid_r <= 1'b0;
        end else begin
            s2_valid_r <= s1_valid_r;
            pat_addr_r <= {map_q_r, s1_yl_r, s1_xl_r};
            s3_valid_r <= s2_valid_r;
        end
    end

    // Resolves the ROM pixel through the palette; inactive coordinates output black.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pix_data_r <= 16'h0000;
        end else if (s3_valid_r) begin
            pix_data_r <= pal_r[pat_data];
        end else begin
            pix_data_r <= 16'h0000;
        end
    end

    // ------------------------------------------------------------------
    // Write port
    // ------------------------------------------------------------------
    assign wr_fire_s = wr_valid && wr_ready_r;

    // Palette writes land in entry wr_addr[3:0]; they are visible to the next pixel leaving S4.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < 16; i++) begin
                pal_r[i] <= 16'h0000;
            end
        end else if (wr_fire_s && wr_sel) begin
            pal_r[wr_addr[3:0]] <= wr_data;
        end
    end

    // The map write port is owned by the clear sweep; otherwise in-range user writes use it.
    always_comb begin
        map_we_s = 1'b0;
        map_wa_s = 11'd0;
        map_wd_s = 8'h00;
        if (state_r == ST_CLEAR) begin
            map_we_s = 1'b1;
            map_wa_s = clr_cnt_r;
            map_wd_s = 8'h00;
        end else if (wr_fire_s && !wr_sel && (wr_addr < MAP_N_L)) begin
            map_we_s = 1'b1;
            map_wa_s = wr_addr;
            map_wd_s = wr_data[7:0];
        end else begin
            map_we_s = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Clear FSM
    // ------------------------------------------------------------------
    // Next-state and sweep-counter logic; clr_req is ignored outside IDLE.
    always_comb begin
        state_s   = state_r;
        clr_cnt_s = clr_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (clr_req) begin
                    state_s   = ST_CLEAR;
                    clr_cnt_s = 11'd0;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_r == MAP_LAST_L) begin
                    state_s = ST_DONE;
                end else begin
                    clr_cnt_s = clr_cnt_r + 11'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s   = ST_IDLE;
                clr_cnt_s = 11'd0;
            end
        endcase
    end

    // State register plus flags registered from the next state, so they line up with it.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r    <= ST_IDLE;
            clr_cnt_r  <= 11'd0;
            wr_ready_r <= 1'b1;
            clr_busy_r <= 1'b0;
            clr_done_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            clr_cnt_r  <= clr_cnt_s;
            wr_ready_r <= (state_s == ST_IDLE);
            clr_busy_r <= (state_s == ST_CLEAR) || (state_s == ST_DONE);
            clr_done_r <= (state_s == ST_DONE);
        end
    end

    assign pix_data = pix_data_r;
    assign pat_addr = pat_addr_r;
    assign wr_ready = wr_ready_r;
    assign clr_busy = clr_busy_r;
    assign clr_done = clr_done_r;

endmodule

// File: tb/tb_tile_fetch.sv
// Self-checking bench for tile_fetch.
// A reference model built from arrays and plain modular arithmetic predicts
// pat_addr (3 cycles after presentation) and pix_data (5 cycles after).
// A synchronous pattern ROM model responds to pat_addr.
// The scroll checks depend on TILE_SCROLL_EN.
module tb_tile_fetch;

    localparam int H  = 640;
    localparam int V  = 480;
    localparam int MW = 40;
    localparam int MN = 1200;

    logic        vga_clk = 1'b0;
    logic        sys_rst_n;
    logic [9:0]  pix_x, pix_y;
    logic [15:0] pix_data, pat_addr;
    logic [3:0]  pat_data = 4'h0;
    logic        wr_valid, wr_ready, wr_sel;
    logic [10:0] wr_addr;
    logic [15:0] wr_data;
    logic [9:0]  scroll_x;
    logic [8:0]  scroll_y;
    logic        clr_req, clr_busy, clr_done;

    int checks = 0;
    int errors = 0;

    logic [7:0]  map_m [0:MN-1];
    logic [15:0] pal_m [0:15];
    int m_sx, m_sy;

    typedef struct { int x; int y; } coord_t;
    typedef struct { bit chk; logic [15:0] val; } exp_t;
    coord_t cq[$];
    exp_t   eq[$];
    exp_t   pq[$];

    tile_fetch #(.H_RES(H), .V_RES(V)) dut (
        .vga_clk(vga_clk), .sys_rst_n(sys_rst_n),
        .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
        .pat_addr(pat_addr), .pat_data(pat_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .scroll_x(scroll_x), .scroll_y(scroll_y),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    always #5 vga_clk = ~vga_clk;

    // Pattern ROM contents: tile 5 is solid colour 3, other tiles mix index and offsets.
    function automatic logic [3:0] rom_f(input logic [15:0] a);
        if (a[15:8] == 8'h05) return 4'h3;
        return a[15:12] ^ a[11:8] ^ a[7:4] ^ a[3:0];
    endfunction

    // Synchronous pattern ROM: data valid one cycle after the address.
    always @(posedge vga_clk) pat_data <= rom_f(pat_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one coordinate now and queue the model's prediction for it.
    task automatic present(input int x, input int y);
        int xs, ys, old_sx, old_sy;
        logic [15:0] a;
        exp_t ep, ea;
        old_sx = m_sx;
        old_sy = m_sy;
        pix_x = 10'(x);
        pix_y = 10'(y);
`ifdef TILE_SCROLL_EN
        if (x == 0 && y == 0) begin
            if (int'(scroll_x) < H) m_sx = int'(scroll_x);
            if (int'(scroll_y) < V) m_sy = int'(scroll_y);
        end
`endif
        if (x < H && y < V) begin
            xs = (x + old_sx) % H;
            ys = (y + old_sy) % V;
            a = {map_m[(ys / 16) * MW + xs / 16], 4'(ys % 16), 4'(xs % 16)};
            ep.chk = 1'b1; ep.val = pal_m[rom_f(a)];
            ea.chk = 1'b1; ea.val = a;
        end else begin
            ep.chk = 1'b1; ep.val = 16'h0000;
            ea.chk = 1'b0; ea.val = 16'h0000;
        end
        if (x == 0 && y == 0 && (m_sx != old_sx || m_sy != old_sy)) begin
            ep.chk = 1'b0;
            ea.chk = 1'b0;
        end
        eq.push_back(ep);
        pq.push_back(ea);
    endtask

    // Advance one clock and compare matured predictions. Then present the next coordinate.
    task automatic tick();
        exp_t e;
        coord_t c;
        @(posedge vga_clk);
        #1;
        if (eq.size() == 5) begin
            e = eq.pop_front();
            if (e.chk) check("pix_data", 32'(pix_data), 32'(e.val));
        end
        if (pq.size() == 3) begin
            e = pq.pop_front();
            if (e.chk) check("pat_addr", 32'(pat_addr), 32'(e.val));
        end
        if (cq.size() > 0) begin
            c = cq.pop_front();
            present(c.x, c.y);
        end else begin
            present(1023, 1023);
        end
    endtask

    task automatic drain();
        while (cq.size() > 0) tick();
        repeat (6) tick();
    endtask

    task automatic wr(input bit sel, input int addr, input logic [15:0] data);
        int k;
        k = 0;
        wr_valid = 1'b1;
        wr_sel   = sel;
        wr_addr  = 11'(addr);
        wr_data  = data;
        while (wr_ready !== 1'b1 && k < 3000) begin
            tick();
            k++;
        end
        check("wr_ready_wait", 32'(wr_ready), 32'd1);
        tick();
        wr_valid = 1'b0;
        if (sel) pal_m[addr % 16] = data;
        else if (addr < MN) map_m[addr] = data[7:0];
    endtask

    // Display one pixel from every map tile, which reads back the whole map.
    task automatic scan_map();
        for (int t = 0; t < MN; t++)
            cq.push_back('{(t % MW) * 16 + (t % 16), (t / MW) * 16 + ((t * 7) % 16)});
        drain();
    endtask

    task automatic fill_palette();
        for (int i = 0; i < 16; i++) wr(1'b1, i, {4'(i), 12'($urandom)});
    endtask

    task automatic fill_map();
        for (int t = 0; t < MN; t++) wr(1'b0, t, 16'($urandom));
    endtask

    task automatic random_stream(input int n);
        for (int i = 0; i < n; i++)
            cq.push_back('{int'($urandom_range(0, 700)), int'($urandom_range(0, 520))});
        drain();
    endtask

    initial begin
        int busy, done_cnt, done_at;
        sys_rst_n = 1'b0;
        pix_x = 10'd1023; pix_y = 10'd1023;
        wr_valid = 1'b0; wr_sel = 1'b0; wr_addr = 11'd0; wr_data = 16'h0000;
        scroll_x = 10'd0; scroll_y = 9'd0; clr_req = 1'b0;
        m_sx = 0; m_sy = 0;
        for (int i = 0; i < 16; i++) pal_m[i] = 16'h0000;
        for (int t = 0; t < MN; t++) map_m[t] = 8'h00;

        // Reset values
        repeat (3) tick();
        check("rst_pix_data", 32'(pix_data), 32'h0);
        check("rst_pat_addr", 32'(pat_addr), 32'h0);
        check("rst_clr_busy", 32'(clr_busy), 32'h0);
        check("rst_clr_done", 32'(clr_done), 32'h0);
        check("rst_wr_ready", 32'(wr_ready), 32'h1);
        sys_rst_n = 1'b1;
        eq.delete(); pq.delete();
        repeat (2) tick();

        // Basic fetch: (0,0) -> pat_addr 0x0500, pix_data 0xF800
        wr(1'b1, 3, 16'hF800);
        wr(1'b0, 0, 16'h0005);
        cq.push_back('{0, 0});
        drain();

        // Map addressing, blanking and random traffic
        fill_palette();
        fill_map();
        wr(1'b0, 1199, 16'h009C);
        cq.push_back('{639, 479});
        cq.push_back('{640, 0});
        cq.push_back('{0, 480});
        cq.push_back('{1023, 5});
        drain();
        random_stream(200);

        // Scroll latch and wrap; a build without the feature ignores these inputs
        scroll_x = 10'd630; scroll_y = 9'd475;
        cq.push_back('{0, 0});
        cq.push_back('{20, 10});
        drain();
        random_stream(150);
        scroll_x = 10'd700; scroll_y = 9'd100;
        cq.push_back('{0, 0});
        cq.push_back('{20, 10});
        drain();
        random_stream(150);
        scroll_x = 10'd0; scroll_y = 9'd0;
        cq.push_back('{0, 0});
        drain();

        // Out-of-range map write is accepted and changes nothing
        wr(1'b0, 1500, 16'h00AB);
        scan_map();

        // Same-cycle write and clear request: the write lands first
        check("wr_ready_pre_clear", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1; wr_sel = 1'b0; wr_addr = 11'd7; wr_data = 16'h0042;
        clr_req = 1'b1;
        tick();
        wr_valid = 1'b0; clr_req = 1'b0;
        map_m[7] = 8'h42;
        cq.push_back('{7 * 16 + 3, 2});
        busy = 0; done_cnt = 0; done_at = -1;
        while (clr_busy === 1'b1 && busy < 3000) begin
            check("wr_ready_in_clear", 32'(wr_ready), 32'd0);
            if (clr_done === 1'b1) begin
                done_cnt++;
                done_at = busy;
            end
            clr_req = (busy == 500) ? 1'b1 : 1'b0;
            busy++;
            tick();
        end
        clr_req = 1'b0;
        check("clr_busy_cycles", 32'(busy), 32'd1201);
        check("clr_done_count", 32'(done_cnt), 32'd1);
        check("clr_done_at", 32'(done_at), 32'd1200);
        check("wr_ready_after_done", 32'(wr_ready), 32'd1);
        check("clr_done_after", 32'(clr_done), 32'd0);
        for (int t = 0; t < MN; t++) map_m[t] = 8'h00;
        scan_map();

        // Reset in the middle of a clear
        fill_map();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (600) tick();
        check("busy_at_600", 32'(clr_busy), 32'd1);
        sys_rst_n = 1'b0;
        #1;
        check("rst_mid_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_mid_clr_busy", 32'(clr_busy), 32'd0);
        check("rst_mid_clr_done", 32'(clr_done), 32'd0);
        check("rst_mid_pix_data", 32'(pix_data), 32'd0);
        eq.delete(); pq.delete();
        for (int t = 0; t < 600; t++) map_m[t] = 8'h00;
        for (int i = 0; i < 16; i++) pal_m[i] = 16'h0000;
        m_sx = 0; m_sy = 0;
        repeat (2) tick();
        sys_rst_n = 1'b1;
        tick();
        fill_palette();
        scan_map();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
